rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port between NREQ write-back requesters (ALU, load unit, multiplier/divider) using round-robin arbitration. It drives the register file's RF_W/rdc/rd inputs from a one-entry output register. It also tracks outstanding destination registers so the issue stage can stall on RAW/WAW hazards.

---
 rtl/rf_wb_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the integer register file
// write port, with a one-entry registered output stage and a destination
// scoreboard that drives the issue-stage hazard stall.
// Optional feature macro: RF_WB_BYPASS_EN (adds byp_* ports and lets a source
// or destination that is being written this cycle bypass the stall).
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_rdc,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 RF_W,
    output logic [4:0]           rdc,
    output logic [XLEN-1:0]      rd,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_rs1c,
    input  logic [4:0]           iss_rs2c,
    input  logic [4:0]           iss_rdc,
    output logic                 iss_stall,
`ifdef RF_WB_BYPASS_EN
    output logic                 byp_valid,
    output logic [4:0]           byp_rdc,
    output logic [XLEN-1:0]      byp_data,
`endif
    output logic [31:0]          busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   idx_hi;
    logic [PW-1:0]   idx_lo;
    logic [PW-1:0]   gidx;
    logic            hit_hi;
    logic            hit_lo;
    logic            grant;
    logic [4:0]      sel_rdc;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy_next;
    logic            alloc;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            haz_rd;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        hit_hi    = 1'b0;
        hit_lo    = 1'b0;
        idx_hi    = '0;
        idx_lo    = '0;
        req_ready = '0;
        sel_rdc   = '0;
        sel_data  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                hit_lo = 1'b1;
                idx_lo = PW'(i);
                if (PW'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    idx_hi = PW'(i);
                end
            end
        end
        grant = hit_lo & ~rst;
        gidx  = hit_hi ? idx_hi : idx_lo;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && (PW'(i) == gidx)) begin
                req_ready[i] = 1'b1;
                sel_rdc      = req_rdc[i*5 +: 5];
                sel_data     = req_data[i*XLEN +: XLEN];
            end
        end
        ptr_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
    end

    // Output stage and rotation pointer; a grant to x0 is consumed without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            RF_W <= 1'b0;
            rdc  <= '0;
            rd   <= '0;
            ptr  <= '0;
        end else begin
            RF_W <= grant && (sel_rdc != 5'd0);
            if (grant) begin
                rdc <= sel_rdc;
                rd  <= sel_data;
                ptr <= ptr_next;
            end
        end
    end

    // Hazard detection; with bypass, a register written this cycle is not a hazard.
    always_comb begin
`ifdef RF_WB_BYPASS_EN
        haz_rs1 = busy[iss_rs1c] & ~(RF_W & (iss_rs1c == rdc));
        haz_rs2 = busy[iss_rs2c] & ~(RF_W & (iss_rs2c == rdc));
        haz_rd  = busy[iss_rdc]  & ~(RF_W & (iss_rdc  == rdc));
`else
        haz_rs1 = busy[iss_rs1c];
        haz_rs2 = busy[iss_rs2c];
        haz_rd  = busy[iss_rdc];
`endif
        iss_stall = iss_valid & (haz_rs1 | haz_rs2 | haz_rd);
        alloc     = iss_valid & ~iss_stall & (iss_rdc != 5'd0);
    end

    // Scoreboard next state: clear on write-back, then set on issue so set wins.
    always_comb begin
        busy_next = busy;
        if (RF_W) begin
            busy_next[rdc] = 1'b0;
        end
        if (alloc) begin
            busy_next[iss_rdc] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign byp_valid = RF_W;
    assign byp_rdc   = rdc;
    assign byp_data  = rd;
`endif

endmodule
